// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
// Groups the fifo read port and the outgoing valid/ready stream of the
// fifo read-side adapter into one bundle.
//   fifo_empty_i  fifo empty flag                   (into the adapter)
//   fifo_data_i   fifo head word                    (into the adapter)
//   fifo_rd_o     fifo pop strobe                   (out of the adapter)
//   out_valid_o   stream valid, registered          (out of the adapter)
//   out_data_o    stream data, registered           (out of the adapter)
//   out_ready_i   stream ready from the consumer    (into the adapter)
// The master modport is the adapter's view. The slave modport is the view of
// whatever surrounds the adapter, meaning the fifo plus the consumer.
interface fifo_rd_stream_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_data_i;
  logic              fifo_rd_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_ready_i;

  modport master (
    input  fifo_empty_i, fifo_data_i, out_ready_i,
    output fifo_rd_o, out_valid_o, out_data_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, out_ready_i,
    input  fifo_rd_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// This module is the read-side adapter for a synchronous fifo. It pops words
// from the fifo and presents them on a registered valid/ready stream.
// A two-entry buffer (h0 is the head, h1 is the second word) keeps the
// throughput at one word per cycle. The fifo pop strobe never depends
// combinationally on out_ready_i. The module also counts every completed
// output handshake.
// Ports:
//   clk      single clock, rising edge
//   reset    synchronous, active-high
//   flush_i  discards all buffered words
//   cnt_o    count of completed output handshakes, modulo 2^CNT_W
//   bus      fifo read port and output stream (fifo_rd_stream_if.master)
module fifo_rd_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  output logic [CNT_W-1:0] cnt_o,
  fifo_rd_stream_if.master bus
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [1:0]        occ_q;
  logic [DATA_W-1:0] h0_q;
  logic [DATA_W-1:0] h1_q;
  logic              pop;
  logic              hs;

  // The pop decision uses only registered occupancy plus the fifo and
  // control inputs. As a result, out_ready_i never reaches fifo_rd_o
  // combinationally.
  assign pop = ~reset & ~flush_i & ~bus.fifo_empty_i & (occ_q != OCC_TWO);
  assign hs  = bus.out_valid_o & bus.out_ready_i;

  assign bus.fifo_rd_o   = pop;
  assign bus.out_valid_o = (occ_q != OCC_EMPTY);
  assign bus.out_data_o  = h0_q;

  // Buffer update. A flush only clears the occupancy, so the stale entries
  // are simply never presented. When one word leaves and a new one arrives
  // at occupancy 1, the new word goes straight into the head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= OCC_EMPTY;
      h0_q  <= '0;
      h1_q  <= '0;
    end else if (flush_i) begin
      occ_q <= OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (pop) begin
            h0_q  <= bus.fifo_data_i;
            occ_q <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (pop && hs) begin
            h0_q <= bus.fifo_data_i;
          end else if (pop) begin
            h1_q  <= bus.fifo_data_i;
            occ_q <= OCC_TWO;
          end else if (hs) begin
            occ_q <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (hs) begin
            h0_q  <= h1_q;
            occ_q <= OCC_ONE;
          end
        end
        default: begin
          occ_q <= occ_q;
        end
      endcase
    end
  end

  // Handshake counter. A flush does not clear it, and a handshake that lands
  // in a flush cycle still counts. The counter wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_o <= '0;
    end else if (hs) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Bench for fifo_rd_stream. The fifo is modelled as a queue of words. The
// adapter's buffer is modelled as a queue of at most two words that are
// waiting to be delivered. A second instance with a 4-bit counter sees the
// same stimulus, so counter wrap is covered as well.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  fifo_rd_stream_if #(.DATA_W(8)) ifc ();
  fifo_rd_stream_if #(.DATA_W(8)) ifc4 ();

  assign ifc4.fifo_empty_i = ifc.fifo_empty_i;
  assign ifc4.fifo_data_i  = ifc.fifo_data_i;
  assign ifc4.out_ready_i  = ifc.out_ready_i;

  fifo_rd_stream #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .cnt_o(cnt), .bus(ifc.master)
  );

  fifo_rd_stream #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush_i(flush), .cnt_o(cnt4), .bus(ifc4.master)
  );

  always #5 clk = ~clk;

  // Model state
  logic [7:0] fq[$];
  logic [7:0] mq[$];
  logic [7:0] delivered[$];
  int         dcyc[$];
  int         mcnt = 0;
  int         pops = 0;
  int         cyc = 0;
  bit         zero_flag = 1'b1;

  int passed = 0;
  int total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic sync_fifo();
    ifc.fifo_empty_i = (fq.size() == 0);
    ifc.fifo_data_i  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    sync_fifo();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sync_fifo();
  endtask

  task automatic wait_delivered(input string name, input int n, input int bound);
    int k = 0;
    while (delivered.size() < n && k < bound) begin
      tick();
      k++;
    end
    check(name, delivered.size(), n);
  endtask

  function automatic logic [31:0] del_at(input int i);
    return (delivered.size() > i) ? {24'h0, delivered[i]} : 32'hDEAD;
  endfunction

  // Reference model: update the queues on each rising edge, using the values
  // that were stable just before that edge.
  always @(posedge clk) begin
    bit hs_m;
    bit pop_m;
    cyc++;
    if (ifc.fifo_rd_o) pops++;
    if (reset) begin
      mq.delete();
      mcnt = 0;
      zero_flag = 1'b1;
    end else begin
      hs_m  = (mq.size() != 0) && ifc.out_ready_i;
      pop_m = !flush && (fq.size() != 0) && (mq.size() < 2);
      if (hs_m) begin
        mcnt++;
        delivered.push_back(mq[0]);
        dcyc.push_back(cyc);
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (hs_m) void'(mq.pop_front());
        if (pop_m) begin
          mq.push_back(fq[0]);
          zero_flag = 1'b0;
        end
      end
      if (pop_m) void'(fq.pop_front());
    end
  end

  // Compare process: check every cycle, midway between rising edges.
  always @(negedge clk) begin
    logic exp_pop;
    logic [31:0] mc;
    exp_pop = !reset && !flush && (fq.size() != 0) && (mq.size() < 2);
    mc = mcnt;
    check("fifo_rd", ifc.fifo_rd_o, exp_pop);
    check("fifo_rd_w4", ifc4.fifo_rd_o, exp_pop);
    check("no_pop_when_empty", ifc.fifo_rd_o & ifc.fifo_empty_i, 1'b0);
    check("out_valid", ifc.out_valid_o, mq.size() != 0);
    check("out_valid_w4", ifc4.out_valid_o, mq.size() != 0);
    if (mq.size() != 0) begin
      check("out_data", ifc.out_data_o, mq[0]);
      check("out_data_w4", ifc4.out_data_o, mq[0]);
    end else if (zero_flag) begin
      check("out_data_reset", ifc.out_data_o, 8'h00);
    end
    check("cnt", cnt, mc[15:0]);
    check("cnt_w4", cnt4, mc[3:0]);
  end

  initial begin
    ifc.out_ready_i = 1'b0;
    sync_fifo();

    // Reset test: hold reset for 3 cycles while the fifo is non-empty.
    push(8'h01); push(8'h02); push(8'h03);
    tick(); tick(); tick();
    check("reset_valid", ifc.out_valid_o, 1'b0);
    check("reset_data", ifc.out_data_o, 8'h00);
    check("reset_cnt", cnt, 16'd0);
    check("reset_pops", pops, 0);
    fq.delete();
    sync_fifo();
    reset = 1'b0;
    tick();

    // Streaming test
    ifc.out_ready_i = 1'b1;
    delivered.delete(); dcyc.delete();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_delivered("stream_count", 4, 20);
    check("stream_w0", del_at(0), 8'h11);
    check("stream_w1", del_at(1), 8'h22);
    check("stream_w2", del_at(2), 8'h33);
    check("stream_w3", del_at(3), 8'h44);
    if (dcyc.size() == 4) check("stream_consecutive", dcyc[3] - dcyc[0], 3);
    check("stream_cnt", cnt, 16'd4);

    // Backpressure test
    ifc.out_ready_i = 1'b0;
    delivered.delete(); dcyc.delete();
    pops = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 1) check("bp_hold_data", ifc.out_data_o, 8'h11);
    end
    check("bp_pops", pops, 2);
    check("bp_valid", ifc.out_valid_o, 1'b1);
    ifc.out_ready_i = 1'b1;
    wait_delivered("bp_count", 4, 20);
    check("bp_w0", del_at(0), 8'h11);
    check("bp_w1", del_at(1), 8'h22);
    check("bp_w2", del_at(2), 8'h33);
    check("bp_w3", del_at(3), 8'h44);
    if (dcyc.size() == 4) check("bp_no_gaps", dcyc[3] - dcyc[0], 3);

    // Flush test: two words buffered and one still in the fifo.
    ifc.out_ready_i = 1'b0;
    delivered.delete(); dcyc.delete();
    pops = 0;
    push(8'hA0); push(8'hA1); push(8'hA2);
    for (int i = 0; i < 10 && pops < 2; i++) tick();
    check("flush_prefill_pops", pops, 2);
    check("flush_prefill_valid", ifc.out_valid_o, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid_after", ifc.out_valid_o, 1'b0);
    check("flush_cnt", cnt, 16'd8);
    ifc.out_ready_i = 1'b1;
    wait_delivered("flush_count", 1, 10);
    check("flush_next_word", del_at(0), 8'hA2);
    tick(); tick();
    check("flush_no_extra", delivered.size(), 1);

    // Empty fifo with random ready
    delivered.delete(); dcyc.delete();
    push(8'h5A);
    for (int i = 0; i < 20; i++) begin
      ifc.out_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    ifc.out_ready_i = 1'b1;
    tick(); tick(); tick();
    check("single_count", delivered.size(), 1);
    check("single_word", del_at(0), 8'h5A);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 8) push(8'($urandom));
      ifc.out_ready_i = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    flush = 1'b0;
    reset = 1'b0;

    // Counter wrap: deliver 17 words after a reset.
    reset = 1'b1;
    tick(); tick();
    fq.delete();
    sync_fifo();
    reset = 1'b0;
    ifc.out_ready_i = 1'b1;
    delivered.delete(); dcyc.delete();
    for (int i = 0; i < 17; i++) push(8'(i + 8'h30));
    wait_delivered("wrap_count", 17, 60);
    check("wrap_cnt4", cnt4, 4'd1);
    check("wrap_cnt16", cnt, 16'd17);
    check("wrap_last", del_at(16), 8'h40);

    tick();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
